// File: rtl/led_pkg.sv
// Shared definitions for the LED level arbiter: FSM state encoding,
// LED bar size and default parameter values.
package led_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } led_state_e;

    localparam int LED_COUNT    = 16;
    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_LVL_W    = 5;
    localparam int DEF_MIN_HOLD = 8;
    localparam int DEF_MAX_HOLD = 255;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr.
// Ports: req_i (requests), ptr_i (start index), win_o (one-hot), valid_o.
module rr_priority_pick
    import led_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = $clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic               valid_o
);

    int j;

    // Walk NUM_REQ slots upward from ptr_i with wrap; first hit wins.
    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!valid_o && req_i[j]) begin
                win_o[j] = 1'b1;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_level_arbiter.sv
// Round-robin arbiter granting one requester the LED level bar at a time.
// Ports: clk, rst_n, req/done/level_in (per requester), gnt, level_out, busy.
module led_level_arbiter
    import led_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int LVL_W    = DEF_LVL_W,
    parameter int MIN_HOLD = DEF_MIN_HOLD,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       done,
    input  logic [NUM_REQ*LVL_W-1:0] level_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [LVL_W-1:0]         level_out,
    output logic                     busy
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MIN = HOLD_W'(MIN_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_REQ - 1);

    led_state_e           state_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [LVL_W-1:0]     level_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     owner_q;
    logic [HOLD_W-1:0]    hold_q;
    logic                 done_lat_q;

    logic [NUM_REQ-1:0]   win_oh;
    logic                 win_vld;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     sel_idx;
    logic [LVL_W-1:0]     sel_lvl;
    logic [LVL_W-1:0]     level_d;
    logic [HOLD_W-1:0]    hold_d;
    logic [PTR_W-1:0]     rr_ptr_d;
    logic                 own_req;
    logic                 own_done;
    logic                 others_req;
    logic                 done_seen;
    logic                 release_d;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .win_o   (win_oh),
        .valid_o (win_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) win_idx = PTR_W'(i);
        end
    end

    // Keep the bar within the physical LED count.
    function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] l);
        if (32'(l) > 32'(LED_COUNT)) return LVL_W'(LED_COUNT);
        else return l;
    endfunction

    // On the grant edge the new winner's level is loaded directly.
    assign sel_idx = (state_q == S_OWN) ? owner_q : win_idx;
    assign sel_lvl = level_in[int'(sel_idx)*LVL_W +: LVL_W];
    assign level_d = clamp_lvl(sel_lvl);

    // gnt_q is one-hot on the owner, so it doubles as the owner mask.
    assign own_req    = |(req & gnt_q);
    assign own_done   = |(done & gnt_q);
    assign others_req = |(req & ~gnt_q);
    assign done_seen  = own_done | done_lat_q;

    assign hold_d   = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    assign rr_ptr_d = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;

    // Request drop releases at once; done waits for the minimum tenure.
    assign release_d = !own_req
                     || (done_seen && hold_q >= HOLD_MIN)
                     || (hold_q == HOLD_MAX && others_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            level_q    <= '0;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            hold_q     <= '0;
            done_lat_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        state_q    <= S_OWN;
                        gnt_q      <= win_oh;
                        owner_q    <= win_idx;
                        rr_ptr_q   <= rr_ptr_d;
                        hold_q     <= HOLD_ONE;
                        level_q    <= level_d;
                        done_lat_q <= 1'b0;
                    end
                end
                S_OWN: begin
                    if (release_d) begin
                        state_q    <= S_GAP;
                        gnt_q      <= '0;
                        level_q    <= '0;
                        hold_q     <= '0;
                        done_lat_q <= 1'b0;
                    end else begin
                        hold_q     <= hold_d;
                        level_q    <= level_d;
                        done_lat_q <= done_seen;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign level_out = level_q;
    assign busy      = (state_q == S_OWN);

endmodule

// File: tb/tb_led_level_arbiter.sv
// Self-checking bench for led_level_arbiter (default parameters).
// Vector table plus hand sequences; expectations flow through a queue.
module tb_led_level_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [19:0] level_in;
    logic [3:0]  gnt;
    logic [4:0]  level_out;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] g;
        logic [4:0] l;
        logic       b;
        string      nm;
    } exp_t;

    typedef struct {
        logic [3:0]  r;
        logic [3:0]  d;
        logic [19:0] lv;
        logic [3:0]  g;
        logic [4:0]  l;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[15];

    always #5 clk = ~clk;

    led_level_arbiter #(
        .NUM_REQ  (4),
        .LVL_W    (5),
        .MIN_HOLD (8),
        .MAX_HOLD (255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .level_in  (level_in),
        .gnt       (gnt),
        .level_out (level_out),
        .busy      (busy)
    );

    function automatic logic [19:0] pk(input int a, input int b,
                                       input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    function automatic logic [4:0] cl(input int v);
        return (v > 16) ? 5'd16 : 5'(v);
    endfunction

    function automatic logic [3:0] oh(input int i);
        logic [3:0] t;
        t = '0;
        t[i] = 1'b1;
        return t;
    endfunction

    task automatic compare(input string nm, input logic [3:0] eg,
                           input logic [4:0] el, input logic eb);
        checks++;
        if (gnt !== eg || level_out !== el || busy !== eb) begin
            errors++;
            $display("FAIL %s: got gnt=%b level=%0d busy=%b, want gnt=%b level=%0d busy=%b",
                     nm, gnt, level_out, busy, eg, el, eb);
        end
    endtask

    // Called at a falling edge: drive, queue expectation, check after rise.
    task automatic step(input logic [3:0] r, input logic [3:0] d,
                        input logic [19:0] l, input logic [3:0] eg,
                        input logic [4:0] el, input string nm);
        exp_t e;
        req      = r;
        done     = d;
        level_in = l;
        e.g  = eg;
        e.l  = el;
        e.b  = (eg != 4'b0);
        e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare(e.nm, e.g, e.l, e.b);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] l1;
        logic [19:0] la;
        logic [19:0] lb;
        int lv1[4];
        int order[5];

        l1 = pk(3, 20, 16, 17);
        la = pk(9, 4, 20, 2);
        lb = pk(9, 4, 7, 2);
        lv1 = '{3, 20, 16, 17};
        order = '{0, 1, 2, 3, 0};

        // rr_ptr is 1 when the table starts; grant 2, then 0.
        tbl[0]  = '{4'b0100, 4'b0000, la, 4'b0100, 5'd16};
        tbl[1]  = '{4'b0100, 4'b0000, la, 4'b0100, 5'd16};
        tbl[2]  = '{4'b0100, 4'b0000, la, 4'b0100, 5'd16};
        tbl[3]  = '{4'b0100, 4'b0100, la, 4'b0100, 5'd16};
        tbl[4]  = '{4'b0100, 4'b1011, la, 4'b0100, 5'd16};
        tbl[5]  = '{4'b0100, 4'b0000, lb, 4'b0100, 5'd7};
        tbl[6]  = '{4'b0100, 4'b0000, lb, 4'b0100, 5'd7};
        tbl[7]  = '{4'b0100, 4'b0000, lb, 4'b0100, 5'd7};
        tbl[8]  = '{4'b0100, 4'b0000, lb, 4'b0000, 5'd0};
        tbl[9]  = '{4'b0000, 4'b0000, lb, 4'b0000, 5'd0};
        tbl[10] = '{4'b0001, 4'b0010, lb, 4'b0001, 5'd9};
        tbl[11] = '{4'b0001, 4'b0001, lb, 4'b0001, 5'd9};
        tbl[12] = '{4'b0000, 4'b0000, lb, 4'b0000, 5'd0};
        tbl[13] = '{4'b0000, 4'b0000, lb, 4'b0000, 5'd0};
        tbl[14] = '{4'b0000, 4'b0000, lb, 4'b0000, 5'd0};

        rst_n    = 1'b0;
        req      = '0;
        done     = '0;
        level_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("reset", 4'b0, 5'd0, 1'b0);
        rst_n = 1'b1;

        // All four request: strict rotation, done at hold 8.
        for (int k = 0; k < 5; k++) begin
            int o;
            o = order[k];
            step(4'hF, 4'h0, l1, oh(o), cl(lv1[o]), "rr_grant");
            for (int h = 2; h <= 8; h++)
                step(4'hF, 4'h0, l1, oh(o), cl(lv1[o]), "rr_hold");
            step(4'hF, oh(o), l1, 4'b0, 5'd0, "rr_gap");
            step(4'hF, 4'h0, l1, 4'b0, 5'd0, "rr_idle");
        end

        // Early done latched, level clamp/update, request drop.
        for (int i = 0; i < 15; i++)
            step(tbl[i].r, tbl[i].d, tbl[i].lv, tbl[i].g, tbl[i].l,
                 $sformatf("vec%0d", i));

        // Pre-emption at MAX_HOLD when another requester waits.
        step(4'b0010, 4'h0, lb, 4'b0010, 5'd4, "pre_grant");
        for (int h = 2; h <= 100; h++)
            step(4'b0010, (h == 10) ? 4'b1101 : 4'b0000, lb,
                 4'b0010, 5'd4, "pre_hold");
        for (int h = 101; h <= 255; h++)
            step(4'b1010, 4'h0, lb, 4'b0010, 5'd4, "pre_wait");
        step(4'b1010, 4'h0, lb, 4'b0000, 5'd0, "pre_gap");
        step(4'b1010, 4'h0, lb, 4'b0000, 5'd0, "pre_idle");
        step(4'b1010, 4'h0, lb, 4'b1000, 5'd2, "pre_next");

        // Lone owner keeps the grant past saturation.
        for (int h = 2; h <= 300; h++)
            step(4'b1000, 4'h0, lb, 4'b1000, 5'd2, "sat_hold");
        step(4'b0000, 4'h0, lb, 4'b0000, 5'd0, "sat_drop");
        step(4'b0000, 4'h0, lb, 4'b0000, 5'd0, "sat_idle");

        // Asynchronous reset in the middle of a tenure.
        step(4'b0100, 4'h0, lb, 4'b0100, 5'd7, "rst_grant");
        for (int h = 2; h <= 5; h++)
            step(4'b0100, 4'h0, lb, 4'b0100, 5'd7, "rst_hold");
        rst_n = 1'b0;
        #1;
        compare("rst_async", 4'b0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        compare("rst_held", 4'b0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1001, 4'h0, lb, 4'b0001, 5'd9, "rst_ptr");
        step(4'b0000, 4'h0, lb, 4'b0000, 5'd0, "rst_gap");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_level_arbiter.md
LED_LEVEL_ARBITER -- requirements
Module: led_level_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of level requesters (2..8).
REQ-002 Parameter LVL_W, default 5, width of LED level code fed to the LED decoder.
REQ-003 Parameter MIN_HOLD, default 8, minimum owner tenure in clk cycles.
REQ-004 Parameter MAX_HOLD, default 255, tenure after which owner is pre-empted if others wait.
REQ-005 clk  in  1  source clock; single clock domain, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req  in  NUM_REQ  per-requester ownership request, level-sensitive.
REQ-008 done  in  NUM_REQ  per-requester release strobe, 1-cycle pulse.
REQ-009 level_in  in  NUM_REQ*LVL_W  packed levels; requester i occupies bits [i*LVL_W +: LVL_W].
REQ-010 gnt  out  NUM_REQ  one-hot grant, registered.
REQ-011 level_out  out  LVL_W  level forwarded to the LED decoder, registered.
REQ-012 busy  out  1  high while any grant is held.

Function
REQ-013 FSM states IDLE, OWN, GAP; encoding defined in the shared package.
REQ-014 IDLE: if any req bit is high at a rising edge, the winner is chosen and the state becomes OWN at that edge, so gnt is visible 1 cycle after req is first sampled.
REQ-015 Winner is the first requester with req high, searching upward (with wrap) from the round-robin pointer rr_ptr.
REQ-016 On each grant, rr_ptr becomes (winner+1) mod NUM_REQ; rr_ptr resets to 0.
REQ-017 OWN: hold counter starts at 1 on grant, increments each cycle, and saturates at MAX_HOLD.
REQ-018 OWN: level_out = min(level_in[owner], 16) each cycle (registered), so the 16-LED range is never exceeded.
REQ-019 OWN exits to GAP when any of these hold: (a) done[owner] is seen and hold >= MIN_HOLD; (b) req[owner] is low; (c) hold == MAX_HOLD and any other req bit is high.
REQ-020 A done[owner] pulse with hold < MIN_HOLD is latched; release then occurs on the cycle hold reaches MIN_HOLD.
REQ-021 done pulses from non-owners are ignored, and so is done in IDLE or GAP.
REQ-022 GAP lasts exactly 1 cycle with gnt = 0 and level_out = 0 (blank frame), then goes to IDLE.
REQ-023 A requester released by pre-emption keeps its req; it is re-arbitrated normally with no priority boost.
REQ-024 With hold == MAX_HOLD and no other requester, the owner keeps the grant indefinitely.
REQ-025 busy = (state == OWN).
REQ-026 Simultaneous requests in IDLE are resolved solely by rr_ptr; the lowest index is never favoured otherwise.

Reset
REQ-027 While rst_n is low: state = IDLE, gnt = 0, level_out = 0, busy = 0, rr_ptr = 0, hold = 0, done latch cleared, all asynchronously.
REQ-028 Reset asserted mid-tenure drops the grant immediately, with no GAP cycle.
REQ-029 After rst_n deasserts, arbitration resumes at the first rising edge.

Structure
REQ-030 Shared package led_pkg holds the state enum, LED_COUNT = 16, and the default parameter constants.
REQ-031 One sub-module, rr_priority_pick, is combinational: it takes (req, rr_ptr) and returns a one-hot winner plus a valid flag.
REQ-032 Target size is 120-400 RTL lines; level_out feeds the existing 5-bit LED decoder input unchanged.

Verification
REQ-033 Reset mid-OWN: rst_n low at hold = 5 -> gnt = 0, level_out = 0 within the same cycle; rr_ptr = 0 after release.
REQ-034 req = 4'b1111 from reset, each owner pulses done at hold 8 -> grants 0,1,2,3,0 in order, each separated by a 1-cycle GAP with level_out = 0.
REQ-035 req[2] only, done[2] at hold 3 -> release occurs at hold 8, not 3; GAP follows.
REQ-036 req[1] held, no done, req[3] rises at hold 100 -> forced release at hold 255; req[3] is granted after the GAP.
REQ-037 Owner level_in = 5'd20 -> level_out = 16; level_in = 5'd7 -> level_out = 7 one cycle later.
REQ-038 req[0] drops at hold 2 -> GAP on the next cycle, and MIN_HOLD is not enforced for the drop.
